countdown_timer_ctrl: RTL and testbench

Sequencing controller for the HH:MM:SS countdown timer datapath. Owns the preset registers (edited field-by-field), the live countdown registers and an IDLE/RUN/PAUSE/EXPIRED state machine. Driven by a 1 Hz tick pulse and pre-conditioned (debounced, edge-detected) key/switch pulses from the top level. Its HH/MM/SS outputs feed the binary-to-BCD and 7-segment converters directly.

---
 rtl/countdown_timer_ctrl_if.sv | 30 +++
 rtl/countdown_timer_ctrl.sv | 171 +++++++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_ctrl_if.sv
// Control and display bundle for the HH:MM:SS countdown controller.
`timescale 1ns/1ps
interface countdown_timer_ctrl_if;
  logic       tick_1hz;
  logic       start_stop;
  logic       clear;
  logic       set_pulse;
  logic [1:0] field_sel;
  logic       plus;
  logic [6:0] hours;
  logic [6:0] minutes;
  logic [6:0] seconds;
  logic [1:0] state;
  logic       expired;
  logic       blink;

  modport master (
    output tick_1hz, start_stop, clear,
    output set_pulse, field_sel, plus,
    input  hours, minutes, seconds,
    input  state, expired, blink
  );

  modport slave (
    input  tick_1hz, start_stop, clear,
    input  set_pulse, field_sel, plus,
    output hours, minutes, seconds,
    output state, expired, blink
  );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer sequencer: preset editing, live countdown,
// IDLE/RUN/PAUSE/EXPIRED control and alarm blink.
`timescale 1ns/1ps
module countdown_timer_ctrl #(
  parameter int HOURS_MAX   = 99,
  parameter int ALARM_TICKS = 10
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  countdown_timer_ctrl_if.slave io
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_EXP   = 2'd3
  } state_e;

  localparam int CW = $clog2(ALARM_TICKS + 1);
  localparam logic [6:0]    HMAX = 7'(HOURS_MAX);
  localparam logic [6:0]    MMAX = 7'd59;
  localparam logic [CW-1:0] AEND = CW'(ALARM_TICKS);

  state_e        state_q, state_d;
  logic [6:0]    ph_q, ph_d, pm_q, pm_d, ps_q, ps_d;
  logic [6:0]    lh_q, lh_d, lm_q, lm_d, ls_q, ls_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          blink_q, blink_d;

  logic [6:0]    dh, dm, ds;
  logic [CW-1:0] cnt_inc;
  logic          preset_zero;
  logic          dec_zero;

  function automatic logic [6:0] wrap_step(
    input logic [6:0] v,
    input logic [6:0] vmax,
    input logic       up
  );
    logic [6:0] r;
    if (up) r = (v >= vmax) ? 7'd0 : v + 7'd1;
    else    r = (v == 7'd0) ? vmax : v - 7'd1;
    return r;
  endfunction

  // Borrow chain; only used in RUN where live is never 00:00:00
  always_comb begin
    ds = ls_q - 7'd1;
    dm = lm_q;
    dh = lh_q;
    if (ls_q == 7'd0) begin
      ds = MMAX;
      if (lm_q != 7'd0) begin
        dm = lm_q - 7'd1;
      end else begin
        dm = MMAX;
        dh = lh_q - 7'd1;
      end
    end
  end

  assign cnt_inc     = cnt_q + CW'(1);
  assign preset_zero = (ph_q == 7'd0) && (pm_q == 7'd0) && (ps_q == 7'd0);
  assign dec_zero    = (dh == 7'd0) && (dm == 7'd0) && (ds == 7'd0);

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    pm_d    = pm_q;
    ps_d    = ps_q;
    lh_d    = lh_q;
    lm_d    = lm_q;
    ls_d    = ls_q;
    cnt_d   = cnt_q;
    blink_d = blink_q;
    unique case (state_q)
      S_IDLE: begin
        if (io.set_pulse) begin
          unique case (io.field_sel)
            2'd0:    ps_d = wrap_step(ps_q, MMAX, io.plus);
            2'd1:    pm_d = wrap_step(pm_q, MMAX, io.plus);
            2'd2:    ph_d = wrap_step(ph_q, HMAX, io.plus);
            default: ;
          endcase
        end
        if (io.start_stop && !preset_zero) begin
          lh_d    = ph_q;
          lm_d    = pm_q;
          ls_d    = ps_q;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (io.clear) begin
          state_d = S_IDLE;
          {lh_d, lm_d, ls_d} = '0;
        end else if (io.tick_1hz && dec_zero) begin
          state_d = S_EXP;
          {lh_d, lm_d, ls_d} = '0;
          cnt_d   = '0;
          blink_d = 1'b0;
        end else begin
          if (io.tick_1hz) begin
            lh_d = dh;
            lm_d = dm;
            ls_d = ds;
          end
          if (io.start_stop) state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (io.clear) begin
          state_d = S_IDLE;
          {lh_d, lm_d, ls_d} = '0;
        end else if (io.start_stop) begin
          state_d = S_RUN;
        end
      end
      S_EXP: begin
        if (io.clear || io.start_stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          blink_d = 1'b0;
        end else if (io.tick_1hz) begin
          if (cnt_inc == AEND) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            blink_d = 1'b0;
          end else begin
            cnt_d   = cnt_inc;
            blink_d = ~blink_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      pm_q    <= '0;
      ps_q    <= '0;
      lh_q    <= '0;
      lm_q    <= '0;
      ls_q    <= '0;
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      pm_q    <= pm_d;
      ps_q    <= ps_d;
      lh_q    <= lh_d;
      lm_q    <= lm_d;
      ls_q    <= ls_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign io.hours   = (state_q == S_IDLE) ? ph_q : lh_q;
  assign io.minutes = (state_q == S_IDLE) ? pm_q : lm_q;
  assign io.seconds = (state_q == S_IDLE) ? ps_q : ls_q;
  assign io.state   = state_q;
  assign io.expired = (state_q == S_EXP);
  assign io.blink   = blink_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: directed scenarios plus random
// stimulus against a total-seconds reference model.
`timescale 1ns/1ps
module tb_countdown_timer_ctrl;

  localparam int HM  = 99;
  localparam int ALT = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  countdown_timer_ctrl_if io ();

  countdown_timer_ctrl #(.HOURS_MAX(HM), .ALARM_TICKS(ALT)) dut (
    .CLOCK_50(clk),
    .reset_n (rst_n),
    .io      (io.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: preset as fields, live as total seconds
  int m_state, p_h, p_m, p_s, live, acnt;
  bit m_blink;

  task automatic model_reset();
    m_state = 0; p_h = 0; p_m = 0; p_s = 0;
    live = 0; acnt = 0; m_blink = 0;
  endtask

  task automatic model_step(input bit tk, ss, cl, sp,
                            input int fs, input bit pl);
    int ptot;
    ptot = p_h * 3600 + p_m * 60 + p_s;
    case (m_state)
      0: begin
        if (sp) begin
          if (fs == 0) p_s = pl ? (p_s + 1) % 60 : (p_s + 59) % 60;
          if (fs == 1) p_m = pl ? (p_m + 1) % 60 : (p_m + 59) % 60;
          if (fs == 2) p_h = pl ? (p_h + 1) % (HM + 1) : (p_h + HM) % (HM + 1);
        end
        if (ss && ptot != 0) begin live = ptot; m_state = 1; end
      end
      1: begin
        if (cl) begin m_state = 0; live = 0; end
        else if (tk && live - 1 == 0) begin
          m_state = 3; live = 0; acnt = 0; m_blink = 0;
        end else begin
          if (tk) live = live - 1;
          if (ss) m_state = 2;
        end
      end
      2: begin
        if (cl) begin m_state = 0; live = 0; end
        else if (ss) m_state = 1;
      end
      default: begin
        if (cl || ss) begin m_state = 0; acnt = 0; m_blink = 0; end
        else if (tk) begin
          acnt++;
          m_blink = !m_blink;
          if (acnt == ALT) begin m_state = 0; acnt = 0; m_blink = 0; end
        end
      end
    endcase
  endtask

  function automatic logic [24:0] exp_vec();
    int h, m, s;
    if (m_state == 0) begin h = p_h; m = p_m; s = p_s; end
    else begin h = live / 3600; m = (live % 3600) / 60; s = live % 60; end
    return {7'(h), 7'(m), 7'(s), 2'(m_state), m_state == 3, m_blink};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {io.hours, io.minutes, io.seconds, io.state, io.expired, io.blink};
  endfunction

  task automatic cyc(input bit tk, ss, cl, sp, input int fs, input bit pl);
    io.tick_1hz = tk; io.start_stop = ss; io.clear = cl;
    io.set_pulse = sp; io.field_sel = 2'(fs); io.plus = pl;
    @(posedge clk);
    model_step(tk, ss, cl, sp, fs, pl);
    #1;
    io.tick_1hz = 0; io.start_stop = 0; io.clear = 0;
    io.set_pulse = 0; io.field_sel = 2'd3; io.plus = 0;
  endtask

  task automatic edit(input int fs, input bit pl, input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, fs, pl);
  endtask

  task automatic apply_reset();
    rst_n = 0;
    #3;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if (dut_vec() !== 25'd0) $display("FAIL reset got=%h exp=0", dut_vec());
    else n_pass++;
  endtask

  task automatic test_edit();
    edit(0, 1, 3);
    edit(0, 0, 1);
    n_chk++;
    if (io.seconds !== 7'd2) $display("FAIL edit_sec got=%0d exp=2", io.seconds);
    else n_pass++;
    edit(2, 0, 1);
    n_chk++;
    if (io.hours !== 7'd99) $display("FAIL edit_hour_wrap got=%0d exp=99", io.hours);
    else n_pass++;
    edit(1, 0, 1);
    edit(3, 1, 2);
    n_chk++;
    if (dut_vec() !== exp_vec()) $display("FAIL edit_model got=%h exp=%h", dut_vec(), exp_vec());
    else n_pass++;
    n_chk++;
    if ({io.hours, io.minutes, io.seconds} !== {7'd99, 7'd59, 7'd2})
      $display("FAIL edit_fields got=%0d:%0d:%0d exp=99:59:2", io.hours, io.minutes, io.seconds);
    else n_pass++;
  endtask

  task automatic test_borrow();
    int bad;
    apply_reset();
    edit(2, 1, 1);
    cyc(0, 1, 0, 0, 3, 0);
    cyc(1, 0, 0, 0, 3, 0);
    n_chk++;
    if ({io.hours, io.minutes, io.seconds, io.state} !== {7'd0, 7'd59, 7'd59, 2'd1})
      $display("FAIL borrow_first got=%0d:%0d:%0d st=%0d exp=0:59:59 st=1",
               io.hours, io.minutes, io.seconds, io.state);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 3599; i++) begin
      cyc(1, 0, 0, 0, 3, 0);
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        if (bad < 5) $display("FAIL borrow_tick%0d got=%h exp=%h", i, dut_vec(), exp_vec());
        bad++;
      end else n_pass++;
    end
    n_chk++;
    if ({io.hours, io.minutes, io.seconds, io.state, io.expired} !== {21'd0, 2'd3, 1'b1})
      $display("FAIL borrow_expire got=%h exp=%h", dut_vec(), {21'd0, 2'd3, 1'b1, 1'b0});
    else n_pass++;
  endtask

  task automatic test_alarm();
    int toggles;
    logic prev;
    toggles = 0;
    for (int i = 0; i < ALT; i++) begin
      prev = io.blink;
      cyc(1, 0, 0, 0, 3, 0);
      if (i < ALT - 1 && io.blink !== prev) toggles++;
      if (i == ALT - 1 && prev === 1'b1) toggles++;
      n_chk++;
      if (dut_vec() !== exp_vec()) $display("FAIL alarm_tick%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (toggles !== ALT) $display("FAIL alarm_toggles got=%0d exp=%0d", toggles, ALT);
    else n_pass++;
    n_chk++;
    if ({io.state, io.blink, io.hours, io.minutes, io.seconds} !== {2'd0, 1'b0, 7'd1, 14'd0})
      $display("FAIL alarm_return got=%h exp=idle 01:00:00", dut_vec());
    else n_pass++;
    apply_reset();
    edit(0, 1, 1);
    cyc(0, 1, 0, 0, 3, 0);
    cyc(1, 0, 0, 0, 3, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 3, 0);
    n_chk++;
    if (io.blink !== 1'b0 || io.state !== 2'd3)
      $display("FAIL alarm_mid got=st%0d b%0d exp=st3 b0", io.state, io.blink);
    else n_pass++;
    cyc(0, 1, 0, 0, 3, 0);
    n_chk++;
    if ({io.state, io.expired, io.blink, io.seconds} !== {2'd0, 1'b0, 1'b0, 7'd1})
      $display("FAIL alarm_ack got=%h exp=idle 00:00:01", dut_vec());
    else n_pass++;
  endtask

  task automatic test_pause();
    apply_reset();
    edit(0, 1, 5);
    cyc(0, 1, 0, 0, 3, 0);
    repeat (2) cyc(1, 0, 0, 0, 3, 0);
    n_chk++;
    if (io.seconds !== 7'd3) $display("FAIL pause_run got=%0d exp=3", io.seconds);
    else n_pass++;
    cyc(0, 1, 0, 0, 3, 0);
    repeat (3) cyc(1, 0, 0, 0, 3, 0);
    n_chk++;
    if ({io.seconds, io.state} !== {7'd3, 2'd2})
      $display("FAIL pause_hold got=%0d st%0d exp=3 st2", io.seconds, io.state);
    else n_pass++;
    cyc(0, 1, 0, 0, 3, 0);
    cyc(1, 0, 0, 0, 3, 0);
    n_chk++;
    if ({io.seconds, io.state} !== {7'd2, 2'd1})
      $display("FAIL pause_resume got=%0d st%0d exp=2 st1", io.seconds, io.state);
    else n_pass++;
  endtask

  task automatic test_simul();
    apply_reset();
    edit(0, 1, 1);
    cyc(0, 1, 0, 0, 3, 0);
    cyc(1, 1, 0, 0, 3, 0);
    n_chk++;
    if ({io.state, io.expired} !== {2'd3, 1'b1})
      $display("FAIL simul_expire got=st%0d exp=st3", io.state);
    else n_pass++;
    cyc(0, 0, 1, 0, 3, 0);
    edit(0, 1, 4);
    cyc(0, 1, 0, 0, 3, 0);
    cyc(1, 1, 0, 0, 3, 0);
    n_chk++;
    if ({io.seconds, io.state} !== {7'd4, 2'd2})
      $display("FAIL simul_pause got=%0d st%0d exp=4 st2", io.seconds, io.state);
    else n_pass++;
    cyc(0, 1, 0, 0, 3, 0);
    cyc(1, 0, 1, 0, 3, 0);
    n_chk++;
    if ({io.state, io.seconds} !== {2'd0, 7'd5})
      $display("FAIL simul_clear got=st%0d s%0d exp=st0 s5", io.state, io.seconds);
    else n_pass++;
  endtask

  task automatic test_edge();
    apply_reset();
    cyc(0, 1, 0, 0, 3, 0);
    n_chk++;
    if (io.state !== 2'd0) $display("FAIL edge_zero_start got=%0d exp=0", io.state);
    else n_pass++;
    edit(0, 1, 3);
    cyc(0, 1, 0, 0, 3, 0);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 3, 0);
    n_chk++;
    if ({io.state, io.seconds} !== {2'd0, 7'd3})
      $display("FAIL edge_set_in_run got=st%0d s%0d exp=st0 s3", io.state, io.seconds);
    else n_pass++;
    cyc(0, 1, 0, 0, 3, 0);
    cyc(1, 0, 0, 0, 3, 0);
    rst_n = 0;
    #2;
    n_chk++;
    if (dut_vec() !== 25'd0) $display("FAIL edge_async_reset got=%h exp=0", dut_vec());
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_random();
    int bad;
    bit tk, ss, cl, sp, pl;
    int fs;
    bad = 0;
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      tk = ($urandom_range(0, 1) == 1);
      ss = ($urandom_range(0, 9) == 0);
      cl = ($urandom_range(0, 59) == 0);
      sp = ($urandom_range(0, 2) == 0);
      fs = int'($urandom_range(0, 3));
      pl = ($urandom_range(0, 3) != 0);
      cyc(tk, ss, cl, sp, fs, pl);
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        if (bad < 5) $display("FAIL random_cyc%0d got=%h exp=%h", i, dut_vec(), exp_vec());
        bad++;
      end else n_pass++;
    end
  endtask

  initial begin
    io.tick_1hz = 0; io.start_stop = 0; io.clear = 0;
    io.set_pulse = 0; io.field_sel = 2'd3; io.plus = 0;
    model_reset();
    test_reset();
    test_edit();
    test_borrow();
    test_alarm();
    test_pause();
    test_simul();
    test_edge();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
